// File: rtl/miriscv_defines.sv
// -----------------------------------------------------------------------------
// miriscv_defines
//   Shared constants for the miriscv instruction decoder: major opcodes,
//   ALU operation codes, ALU operand selects, load/store sizes and
//   write-back source selects.
//   No ports (package).
// -----------------------------------------------------------------------------
package miriscv_defines;

    localparam int unsigned ALU_OP_WIDTH = 5;

    // Major opcode field, instr[6:2]
    typedef enum logic [4:0] {
        OPC_LOAD     = 5'b00000,
        OPC_MISC_MEM = 5'b00011,
        OPC_OP_IMM   = 5'b00100,
        OPC_AUIPC    = 5'b00101,
        OPC_STORE    = 5'b01000,
        OPC_OP       = 5'b01100,
        OPC_LUI      = 5'b01101,
        OPC_BRANCH   = 5'b11000,
        OPC_JALR     = 5'b11001,
        OPC_JAL      = 5'b11011,
        OPC_SYSTEM   = 5'b11100
    } opcode_e;

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_ADD  = 5'b11000,
        ALU_SUB  = 5'b11001,
        ALU_SLL  = 5'b00111,
        ALU_SLTS = 5'b00010,
        ALU_SLTU = 5'b00011,
        ALU_XOR  = 5'b01111,
        ALU_SRL  = 5'b00101,
        ALU_SRA  = 5'b00100,
        ALU_OR   = 5'b01110,
        ALU_AND  = 5'b10101,
        ALU_EQ   = 5'b01100,
        ALU_NE   = 5'b01101,
        ALU_LTS  = 5'b00000,
        ALU_GES  = 5'b10100,
        ALU_LTU  = 5'b00001,
        ALU_GEU  = 5'b01011
    } alu_op_e;

    typedef enum logic [1:0] {
        OP_A_RS1     = 2'd0,
        OP_A_CURR_PC = 2'd1,
        OP_A_ZERO    = 2'd2
    } op_a_sel_e;

    typedef enum logic [2:0] {
        OP_B_RS2   = 3'd0,
        OP_B_IMM_I = 3'd1,
        OP_B_IMM_U = 3'd2,
        OP_B_IMM_S = 3'd3,
        OP_B_INCR  = 3'd4
    } op_b_sel_e;

    typedef enum logic [2:0] {
        LDST_B  = 3'd0,
        LDST_H  = 3'd1,
        LDST_W  = 3'd2,
        LDST_BU = 3'd4,
        LDST_HU = 3'd5
    } mem_size_e;

    typedef enum logic {
        WB_EX_RESULT = 1'b0,
        WB_LSU_DATA  = 1'b1
    } wb_sel_e;

    localparam logic [6:0] FUNCT7_BASE = 7'h00;
    localparam logic [6:0] FUNCT7_ALT  = 7'h20;

    // Register/immediate arithmetic mapping shared by OP and OP_IMM.
    // 'alt' selects the arithmetic right shift for funct3 = 5.
    function automatic alu_op_e arith_alu_op(input logic [2:0] funct3,
                                             input logic       alt);
        alu_op_e op;
        case (funct3)
            3'd0:    op = ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLTS;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Conditional branch comparison; returns ADD for the reserved codes,
    // which the caller flags as illegal.
    function automatic alu_op_e branch_alu_op(input logic [2:0] funct3);
        alu_op_e op;
        case (funct3)
            3'd0:    op = ALU_EQ;
            3'd1:    op = ALU_NE;
            3'd4:    op = ALU_LTS;
            3'd5:    op = ALU_GES;
            3'd6:    op = ALU_LTU;
            3'd7:    op = ALU_GEU;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/miriscv_decode.sv
// -----------------------------------------------------------------------------
// miriscv_decode
//   Purely combinational RV32I instruction decoder.
//   Ports:
//     clk_i, rst_n_i      clock / synchronous active-low reset (do not
//                         influence any output)
//     fetched_instr_i     32-bit instruction word
//     ex_op_a_sel_o       ALU operand A select
//     ex_op_b_sel_o       ALU operand B select
//     alu_op_o            ALU operation code
//     mem_req_o/mem_we_o  memory request / write enable
//     mem_size_o          load/store access size
//     gpr_we_a_o          register-file write enable
//     wb_src_sel_o        write-back source select
//     illegal_instr_o     illegal instruction flag
//     branch_o/jal_o/jarl_o  conditional branch, JAL, JALR
// -----------------------------------------------------------------------------
module miriscv_decode
    import miriscv_defines::*;
(
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [31:0]             fetched_instr_i,
    output logic [1:0]              ex_op_a_sel_o,
    output logic [2:0]              ex_op_b_sel_o,
    output logic [ALU_OP_WIDTH-1:0] alu_op_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [2:0]              mem_size_o,
    output logic                    gpr_we_a_o,
    output logic                    wb_src_sel_o,
    output logic                    illegal_instr_o,
    output logic                    branch_o,
    output logic                    jal_o,
    output logic                    jarl_o
);

    logic [4:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = fetched_instr_i[6:2];
    assign funct3 = fetched_instr_i[14:12];
    assign funct7 = fetched_instr_i[31:25];

    // Raw decode of the fields, before the illegal override
    op_a_sel_e dec_op_a;
    op_b_sel_e dec_op_b;
    alu_op_e   dec_alu;
    logic      dec_mem_req;
    logic      dec_mem_we;
    mem_size_e dec_size;
    logic      dec_gpr_we;
    wb_sel_e   dec_wb;
    logic      dec_branch;
    logic      dec_jal;
    logic      dec_jalr;
    logic      illegal;

    always_comb begin
        dec_op_a    = OP_A_RS1;
        dec_op_b    = OP_B_RS2;
        dec_alu     = ALU_ADD;
        dec_mem_req = 1'b0;
        dec_mem_we  = 1'b0;
        dec_size    = LDST_W;
        dec_gpr_we  = 1'b0;
        dec_wb      = WB_EX_RESULT;
        dec_branch  = 1'b0;
        dec_jal     = 1'b0;
        dec_jalr    = 1'b0;
        illegal     = (fetched_instr_i[1:0] != 2'b11);

        case (opcode)
            OPC_LOAD: begin
                dec_op_b    = OP_B_IMM_I;
                dec_mem_req = 1'b1;
                dec_gpr_we  = 1'b1;
                dec_wb      = WB_LSU_DATA;
                dec_size    = mem_size_e'(funct3);
                if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) begin
                    illegal = 1'b1;
                end
            end

            OPC_STORE: begin
                dec_op_b    = OP_B_IMM_S;
                dec_mem_req = 1'b1;
                dec_mem_we  = 1'b1;
                dec_size    = mem_size_e'(funct3);
                if (funct3 >= 3'd3) begin
                    illegal = 1'b1;
                end
            end

            OPC_OP_IMM: begin
                dec_op_b   = OP_B_IMM_I;
                dec_gpr_we = 1'b1;
                dec_alu    = arith_alu_op(funct3, funct7 == FUNCT7_ALT);
                // Only the shift encodings constrain funct7
                if (funct3 == 3'd1 && funct7 != FUNCT7_BASE) begin
                    illegal = 1'b1;
                end
                if (funct3 == 3'd5 && funct7 != FUNCT7_BASE && funct7 != FUNCT7_ALT) begin
                    illegal = 1'b1;
                end
            end

            OPC_OP: begin
                dec_gpr_we = 1'b1;
                if (funct7 == FUNCT7_BASE) begin
                    dec_alu = arith_alu_op(funct3, 1'b0);
                end else if (funct7 == FUNCT7_ALT) begin
                    if (funct3 == 3'd0) begin
                        dec_alu = ALU_SUB;
                    end else if (funct3 == 3'd5) begin
                        dec_alu = ALU_SRA;
                    end else begin
                        illegal = 1'b1;
                    end
                end else begin
                    illegal = 1'b1;
                end
            end

            OPC_LUI: begin
                dec_op_a   = OP_A_ZERO;
                dec_op_b   = OP_B_IMM_U;
                dec_gpr_we = 1'b1;
            end

            OPC_AUIPC: begin
                dec_op_a   = OP_A_CURR_PC;
                dec_op_b   = OP_B_IMM_U;
                dec_gpr_we = 1'b1;
            end

            OPC_BRANCH: begin
                dec_branch = 1'b1;
                dec_alu    = branch_alu_op(funct3);
                if (funct3 == 3'd2 || funct3 == 3'd3) begin
                    illegal = 1'b1;
                end
            end

            OPC_JAL: begin
                dec_op_a   = OP_A_CURR_PC;
                dec_op_b   = OP_B_INCR;
                dec_gpr_we = 1'b1;
                dec_jal    = 1'b1;
            end

            OPC_JALR: begin
                dec_op_a   = OP_A_CURR_PC;
                dec_op_b   = OP_B_INCR;
                dec_gpr_we = 1'b1;
                dec_jalr   = 1'b1;
            end

            OPC_MISC_MEM, OPC_SYSTEM: begin
                // Legal NOPs: defaults already apply
            end

            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    // Illegal instructions present the default field values, which also
    // keeps mem_size_o away from the unused encodings 3, 6 and 7.
    always_comb begin
        ex_op_a_sel_o   = OP_A_RS1;
        ex_op_b_sel_o   = OP_B_RS2;
        alu_op_o        = ALU_ADD;
        mem_req_o       = 1'b0;
        mem_we_o        = 1'b0;
        mem_size_o      = LDST_W;
        gpr_we_a_o      = 1'b0;
        wb_src_sel_o    = WB_EX_RESULT;
        branch_o        = 1'b0;
        jal_o           = 1'b0;
        jarl_o          = 1'b0;
        illegal_instr_o = illegal;
        if (!illegal) begin
            ex_op_a_sel_o = dec_op_a;
            ex_op_b_sel_o = dec_op_b;
            alu_op_o      = dec_alu;
            mem_req_o     = dec_mem_req;
            mem_we_o      = dec_mem_we;
            mem_size_o    = dec_size;
            gpr_we_a_o    = dec_gpr_we;
            wb_src_sel_o  = dec_wb;
            branch_o      = dec_branch;
            jal_o         = dec_jal;
            jarl_o        = dec_jalr;
        end
    end

    // Clock and reset are part of the pipeline-stage interface but the
    // decoder is stateless; this flop only absorbs them and drives nothing.
    logic unused_rst_seen_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            unused_rst_seen_q <= 1'b0;
        end else begin
            unused_rst_seen_q <= 1'b1;
        end
    end

    // Register specifiers and immediates are not needed for control decode
    logic unused_instr_bits;
    assign unused_instr_bits = ^{fetched_instr_i[24:15], fetched_instr_i[11:7]};

endmodule

// File: tb/tb_miriscv_decode.sv
module tb_miriscv_decode;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic [1:0]  op_a;
    logic [2:0]  op_b;
    logic [4:0]  alu;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  mem_size;
    logic        gpr_we;
    logic        wb_sel;
    logic        illegal;
    logic        branch;
    logic        jal;
    logic        jalr;

    miriscv_decode dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .fetched_instr_i (instr),
        .ex_op_a_sel_o   (op_a),
        .ex_op_b_sel_o   (op_b),
        .alu_op_o        (alu),
        .mem_req_o       (mem_req),
        .mem_we_o        (mem_we),
        .mem_size_o      (mem_size),
        .gpr_we_a_o      (gpr_we),
        .wb_src_sel_o    (wb_sel),
        .illegal_instr_o (illegal),
        .branch_o        (branch),
        .jal_o           (jal),
        .jarl_o          (jalr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] w;
        logic [1:0]  op_a;
        logic [2:0]  op_b;
        logic [4:0]  alu;
        logic        mem_req;
        logic        mem_we;
        logic [2:0]  size;
        logic        gpr_we;
        logic        wb;
        logic        ill;
        logic        br;
        logic        jal;
        logic        jalr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   driving_done = 0;

    // ALU codes straight from the code table, indexed by funct3
    localparam logic [4:0] ARITH_TAB [8] = '{5'b11000, 5'b00111, 5'b00010, 5'b00011,
                                            5'b01111, 5'b00101, 5'b01110, 5'b10101};
    localparam logic [4:0] BR_TAB    [8] = '{5'b01100, 5'b01101, 5'b11000, 5'b11000,
                                            5'b00000, 5'b10100, 5'b00001, 5'b01011};
    localparam logic [4:0] LEGAL_OPC [11] = '{5'b00000, 5'b00011, 5'b00100, 5'b00101,
                                             5'b01000, 5'b01100, 5'b01101, 5'b11000,
                                             5'b11001, 5'b11011, 5'b11100};

    function automatic exp_t defaults(input logic [31:0] w);
        exp_t e;
        e = '0;
        e.w    = w;
        e.alu  = 5'b11000;
        e.size = 3'd2;
        return e;
    endfunction

    function automatic exp_t model(input logic [31:0] w);
        exp_t       e;
        logic [4:0] opc;
        int         f3;
        logic [6:0] f7;
        bit         bad;
        e   = defaults(w);
        opc = w[6:2];
        f3  = int'(w[14:12]);
        f7  = w[31:25];
        bad = (w[1:0] != 2'b11);
        case (opc)
            5'b00000: begin
                e.op_b = 1; e.mem_req = 1; e.gpr_we = 1; e.wb = 1; e.size = 3'(f3);
                if (f3 == 3 || f3 == 6 || f3 == 7) bad = 1;
            end
            5'b01000: begin
                e.op_b = 3; e.mem_req = 1; e.mem_we = 1; e.size = 3'(f3);
                if (f3 >= 3) bad = 1;
            end
            5'b00100: begin
                e.op_b = 1; e.gpr_we = 1;
                if (f3 == 1 && f7 != 0) bad = 1;
                if (f3 == 5) begin
                    if (f7 == 7'h20) e.alu = 5'b00100;
                    else if (f7 == 0) e.alu = 5'b00101;
                    else bad = 1;
                end else begin
                    e.alu = ARITH_TAB[f3];
                end
            end
            5'b01100: begin
                e.gpr_we = 1;
                if (f7 == 0) e.alu = ARITH_TAB[f3];
                else if (f7 == 7'h20 && f3 == 0) e.alu = 5'b11001;
                else if (f7 == 7'h20 && f3 == 5) e.alu = 5'b00100;
                else bad = 1;
            end
            5'b01101: begin e.op_a = 2; e.op_b = 2; e.gpr_we = 1; end
            5'b00101: begin e.op_a = 1; e.op_b = 2; e.gpr_we = 1; end
            5'b11000: begin
                e.br = 1; e.alu = BR_TAB[f3];
                if (f3 == 2 || f3 == 3) bad = 1;
            end
            5'b11011: begin e.op_a = 1; e.op_b = 4; e.gpr_we = 1; e.jal = 1; end
            5'b11001: begin e.op_a = 1; e.op_b = 4; e.gpr_we = 1; e.jalr = 1; end
            5'b00011, 5'b11100: ;
            default: bad = 1;
        endcase
        if (bad) begin
            e = defaults(w);
            e.ill = 1;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] w,
                         input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s instr=%08h got=%0h expected=%0h", name, w, act, req);
        end
    endtask

    // Monitor: decode is combinational, so outputs are sampled mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("instr_echo", e.w, {7'd0, instr == e.w}, 8'd1);
            check("op_a",    e.w, {6'd0, op_a},     {6'd0, e.op_a});
            check("op_b",    e.w, {5'd0, op_b},     {5'd0, e.op_b});
            check("alu_op",  e.w, {3'd0, alu},      {3'd0, e.alu});
            check("mem_req", e.w, {7'd0, mem_req},  {7'd0, e.mem_req});
            check("mem_we",  e.w, {7'd0, mem_we},   {7'd0, e.mem_we});
            check("size",    e.w, {5'd0, mem_size}, {5'd0, e.size});
            check("gpr_we",  e.w, {7'd0, gpr_we},   {7'd0, e.gpr_we});
            check("wb_sel",  e.w, {7'd0, wb_sel},   {7'd0, e.wb});
            check("illegal", e.w, {7'd0, illegal},  {7'd0, e.ill});
            check("branch",  e.w, {7'd0, branch},   {7'd0, e.br});
            check("jal",     e.w, {7'd0, jal},      {7'd0, e.jal});
            check("jalr",    e.w, {7'd0, jalr},     {7'd0, e.jalr});
        end
    end

    task automatic drive(input logic [31:0] w);
        @(posedge clk);
        #1;
        instr = w;
        exp_q.push_back(model(w));
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        int          k;
        w = $urandom;
        if ($urandom_range(0, 9) < 8) begin
            w[1:0] = 2'b11;
            w[6:2] = LEGAL_OPC[$urandom_range(0, 10)];
        end
        k = $urandom_range(0, 3);
        if (k == 0) w[31:25] = 7'h00;
        else if (k == 1) w[31:25] = 7'h20;
        return w;
    endfunction

    localparam logic [31:0] DIRECTED [12] = '{
        32'h00000013, 32'h40B50533, 32'h00452283, 32'h0000006F,
        32'h00003003, 32'h00000012, 32'h02000033, 32'h40005013,
        32'hFFFFFFFF, 32'h00002063, 32'h00000073, 32'h0000000F
    };

    initial begin
        rst_n = 1'b0;
        instr = 32'h0;
        // First vectors decode while reset is still asserted
        for (int i = 0; i < 12; i++) begin
            drive(DIRECTED[i]);
            if (i == 5) rst_n = 1'b1;
        end
        for (int i = 0; i < 2000; i++) begin
            if (i == 700) rst_n = 1'b0;
            if (i == 720) rst_n = 1'b1;
            drive(gen_instr());
        end
        driving_done = 1;
    end

    initial begin
        int budget;
        wait (driving_done == 1);
        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached before end of stimulus");
        $fatal(1, "timeout");
    end

endmodule
